// File: rtl/coin_acceptor_if.sv
// Coin-acceptor signal bundle: raw sensors and hold in, coin code and status out.
interface coin_acceptor_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          coin5_raw;
  logic                          coin10_raw;
  logic                          hold;
  logic [1:0]                    coin_out;
  logic                          reject;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output coin5_raw, coin10_raw, hold,
    input  coin_out, reject, overflow, fifo_count
  );

  modport slave (
    input  coin5_raw, coin10_raw, hold,
    output coin_out, reject, overflow, fifo_count
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronise, debounce, detect insertions, queue them and
// emit each coin as a single-cycle code with an enforced idle gap.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  coin_acceptor_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, GAP = 2'd2} state_t;

  // Channel index 0 is the 5 rs sensor, index 1 the 10 rs sensor.
  logic [1:0]    raw_s;
  logic [1:0]    sync1_r, sync2_r;
  logic [1:0]    deb_r;
  logic [1:0]    ev_r;
  logic [DW-1:0] deb_cnt_r [2];

  logic [1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          reject_r, overflow_r;

  state_t        state_r, state_nxt_s;
  logic [GW-1:0] gap_r, gap_nxt_s;
  logic [1:0]    coin_out_r, coin_out_nxt_s;
  logic          pop_s;

  logic          push_s, both_s, full_s, empty_s, accept_s;
  logic [1:0]    push_code_s, head_s;

  assign raw_s = {bus.coin10_raw, bus.coin5_raw};

  // Two-flop synchroniser per raw sensor line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce each channel and pulse an event on a debounced rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_r <= 2'b00;
      ev_r  <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        ev_r[i] <= 1'b0;
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= '0;
        end else if (deb_cnt_r[i] == DEB_MAX) begin
          deb_r[i]     <= sync2_r[i];
          deb_cnt_r[i] <= '0;
          ev_r[i]      <= sync2_r[i];
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
        end
      end
    end
  end

  assign push_s      = ev_r[0] ^ ev_r[1];
  assign both_s      = ev_r[0] & ev_r[1];
  assign push_code_s = ev_r[1] ? 2'b10 : 2'b01;
  assign full_s      = (count_r == FULL_CNT);
  assign empty_s     = (count_r == {CW{1'b0}});
  assign accept_s    = push_s & (~full_s | pop_s);
  assign head_s      = mem_r[rd_ptr_r];

  // Coin FIFO plus reject/overflow pulses; a pop frees a slot for a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      reject_r   <= 1'b0;
      overflow_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 2'b00;
    end else begin
      reject_r   <= both_s;
      overflow_r <= push_s & full_s & ~pop_s;
      if (accept_s) begin
        mem_r[wr_ptr_r] <= push_code_s;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_r + CW'(accept_s) - CW'(pop_s);
    end
  end

  // Emission state, gap counter and registered coin code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      gap_r      <= '0;
      coin_out_r <= 2'b00;
    end else begin
      state_r    <= state_nxt_s;
      gap_r      <= gap_nxt_s;
      coin_out_r <= coin_out_nxt_s;
    end
  end

  // Next-state logic. The IDLE decision cycle is the last of the GAP_CYCLES idle
  // cycles, so the GAP state itself lasts GAP_CYCLES-1 cycles.
  always_comb begin
    state_nxt_s    = state_r;
    gap_nxt_s      = gap_r;
    coin_out_nxt_s = 2'b00;
    pop_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && !bus.hold) begin
          coin_out_nxt_s = head_s;
          pop_s          = 1'b1;
          state_nxt_s    = EMIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EMIT: begin
        gap_nxt_s   = GAP_LOAD;
        state_nxt_s = (GAP_CYCLES > 1) ? GAP : IDLE;
      end
      GAP: begin
        gap_nxt_s = gap_r - 1'b1;
        if (gap_r <= {{(GW-1){1'b0}}, 1'b1}) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign bus.coin_out   = coin_out_r;
  assign bus.reject     = reject_r;
  assign bus.overflow   = overflow_r;
  assign bus.fifo_count = count_r;
endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random sensor
// traffic, all compared cycle by cycle against an edge-level behavioural model.
module tb_coin_acceptor;
  localparam int DEB   = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus ();

  coin_acceptor #(
    .DEB_CYCLES(DEB),
    .GAP_CYCLES(GAP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: raw sample history per sensor, a queue of coin codes and
  // the earliest edge at which the next coin may be emitted.
  logic [15:0] m_hist [2];
  logic [1:0]  m_deb, m_ev;
  logic [1:0]  m_q [$];
  int          m_edge, m_next_ok;
  logic [1:0]  m_out;
  logic        m_rej, m_ovf;

  task automatic model_reset();
    m_hist[0] = '0;
    m_hist[1] = '0;
    m_deb = 2'b00;
    m_ev  = 2'b00;
    m_q.delete();
    m_edge = 0;
    m_next_ok = 0;
    m_out = 2'b00;
    m_rej = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] raw, deb_n, ev_n;
    logic       stable, pop;
    int         pre_size;
    if (rst) begin
      model_reset();
      return;
    end
    raw = {bus.coin10_raw, bus.coin5_raw};
    deb_n = m_deb;
    ev_n = 2'b00;
    for (int c = 0; c < 2; c++) begin
      m_hist[c] = {m_hist[c][14:0], raw[c]};
      // The synchronised view lags raw by two edges; a level change needs DEB
      // consecutive synchronised samples that disagree with the current level.
      stable = 1'b1;
      for (int j = 2; j < DEB + 2; j++) if (m_hist[c][j] == m_deb[c]) stable = 1'b0;
      if (stable) begin
        deb_n[c] = ~m_deb[c];
        ev_n[c]  = ~m_deb[c];
      end
    end
    pre_size = m_q.size();
    pop = (m_edge >= m_next_ok) && (pre_size > 0) && !bus.hold;
    m_out = 2'b00;
    if (pop) begin
      m_out = m_q.pop_front();
      m_next_ok = m_edge + 1 + GAP;
    end
    m_rej = m_ev[0] & m_ev[1];
    m_ovf = 1'b0;
    if (m_ev[0] ^ m_ev[1]) begin
      if (pre_size == DEPTH && !pop) m_ovf = 1'b1;
      else m_q.push_back(m_ev[1] ? 2'b10 : 2'b01);
    end
    m_deb = deb_n;
    m_ev = ev_n;
    m_edge++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("coin_out", bus.coin_out, m_out);
    check_eq("reject", bus.reject, m_rej);
    check_eq("overflow", bus.overflow, m_ovf);
    check_eq("fifo_count", bus.fifo_count, m_q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.coin5_raw = 1'b0;
    bus.coin10_raw = 1'b0;
    bus.hold = 1'b0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();
  endtask

  int pulses, at, peak, nrej, novf, code, d5, d10;
  int codes [$];
  int times [$];
  bit seen;

  task automatic tally(input int i);
    if (bus.coin_out != 2'b00) begin
      pulses++;
      at = i;
      code = bus.coin_out;
      codes.push_back(bus.coin_out);
      times.push_back(i);
    end
    if (bus.fifo_count > peak) peak = bus.fifo_count;
    if (bus.reject) nrej++;
    if (bus.overflow) novf++;
  endtask

  task automatic clear_tally();
    pulses = 0; at = -1; peak = 0; nrej = 0; novf = 0; code = 0;
    codes.delete();
    times.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.coin5_raw = 1'b0;
    bus.coin10_raw = 1'b0;
    bus.hold = 1'b0;
    #2;
    check_eq("reset_coin_out", bus.coin_out, 2'b00);
    check_eq("reset_count", bus.fifo_count, 0);
    check_eq("reset_flags", {bus.reject, bus.overflow}, 2'b00);

    // Single 10 rs coin: code appears after edge DEB+3.
    do_reset();
    clear_tally();
    bus.coin10_raw = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) bus.coin10_raw = 1'b0;
      cycle();
      tally(i);
    end
    check_eq("t1_pulses", pulses, 1);
    check_eq("t1_latency", at, DEB + 3);
    check_eq("t1_code", code, 2);
    check_eq("t1_peak", peak, 1);
    check_eq("t1_flags", nrej + novf, 0);

    // Short glitch is ignored.
    clear_tally();
    bus.coin5_raw = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) bus.coin5_raw = 1'b0;
      cycle();
      tally(i);
    end
    check_eq("t2_pulses", pulses, 0);
    check_eq("t2_peak", peak, 0);
    check_eq("t2_flags", nrej + novf, 0);

    // Both sensors together: rejected.
    clear_tally();
    bus.coin5_raw = 1'b1;
    bus.coin10_raw = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) begin
        bus.coin5_raw = 1'b0;
        bus.coin10_raw = 1'b0;
      end
      cycle();
      tally(i);
    end
    check_eq("t3_reject", nrej, 1);
    check_eq("t3_pulses", pulses, 0);
    check_eq("t3_peak", peak, 0);

    // Held FIFO overflows on the fifth coin, then drains in order.
    clear_tally();
    bus.hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 16; i++) begin
        bus.coin5_raw  = (i < 8) && (k % 2 == 0);
        bus.coin10_raw = (i < 8) && (k % 2 == 1);
        cycle();
        tally(i);
      end
    end
    bus.coin5_raw = 1'b0;
    bus.coin10_raw = 1'b0;
    check_eq("t4_peak", peak, DEPTH);
    check_eq("t4_overflow", novf, 1);
    check_eq("t4_held_pulses", pulses, 0);
    clear_tally();
    bus.hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      tally(i);
    end
    check_eq("t4_emitted", codes.size(), 4);
    for (int k = 0; k < codes.size() && k < 4; k++) begin
      check_eq("t4_order", codes[k], (k % 2 == 0) ? 1 : 2);
      if (k > 0) check_eq("t4_spacing", times[k] - times[k-1], 1 + GAP);
    end
    check_eq("t4_drained", bus.fifo_count, 0);

    // Reset during the gap discards queued coins at once.
    clear_tally();
    bus.hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        bus.coin5_raw  = (i < 8) && (k == 0);
        bus.coin10_raw = (i < 8) && (k == 1);
        cycle();
      end
    end
    bus.hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (bus.coin_out != 2'b00) seen = 1'b1;
    end
    check_eq("t5_emit_seen", seen, 1'b1);
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_coin_out", bus.coin_out, 2'b00);
    check_eq("t5_rst_count", bus.fifo_count, 0);
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      tally(i);
    end
    check_eq("t5_after_pulses", pulses, 0);

    // Chattering 10 rs sensor yields exactly one coin.
    clear_tally();
    for (int i = 0; i < 34; i++) begin
      bus.coin10_raw = (i < 6) ? ((i % 2) == 0) : (i < 14);
      cycle();
      tally(i);
    end
    check_eq("t6_pulses", pulses, 1);
    check_eq("t6_code", code, 2);
    check_eq("t6_flags", nrej + novf, 0);

    // Random sensor traffic, hold toggling and occasional resets.
    d5 = 0;
    d10 = 0;
    for (int i = 0; i < 4000; i++) begin
      if (d5 == 0) begin
        bus.coin5_raw = 1'($urandom_range(0, 1));
        d5 = $urandom_range(1, 12);
      end
      if (d10 == 0) begin
        bus.coin10_raw = 1'($urandom_range(0, 2) == 0);
        d10 = $urandom_range(1, 12);
      end
      d5--;
      d10--;
      if ($urandom_range(0, 19) == 0) bus.hold = ~bus.hold;
      rst = ($urandom_range(0, 599) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
